rvsteel_dma: RTL and testbench

RVSTEEL_DMA -- requirements
Module: rvsteel_dma

---
 rtl/rvsteel_dma_pkg.sv | 20 ++
 rtl/rvsteel_dma_regs.sv | 68 ++++++
 rtl/rvsteel_dma.sv | 78 +++++++
 tb/tb_rvsteel_dma.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rvsteel_dma_pkg.sv
// rvsteel_dma_pkg: register map, control bit positions and FSM encodings
package rvsteel_dma_pkg;
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;
  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_DONE  = 2;
  localparam int CTRL_IE    = 3;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_READ   = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;
  function automatic logic [31:0] apply_strobe(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = strb[i] ? nw[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/rvsteel_dma_regs.sv
// rvsteel_dma_regs: managed-port register file with done/irq tracking
module rvsteel_dma_regs
  import rvsteel_dma_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
  output logic        irq,
  input  logic        irq_response,
  input  logic        busy,
  input  logic        done_set,
  output logic        start,
  output logic [31:0] src,
  output logic [31:0] dst,
  output logic [15:0] len
);
  logic [1:0]  sel;
  logic        ctrl_wr, done_clr, ie, done;
  logic [31:0] src_n, dst_n, len_n, ctrl, rdata;
  logic        unused;
  assign unused = ^{rw_address[31:4], rw_address[1:0], dst_n[1:0], len_n[31:16]};
  // decode writes and build the read mux
  always_comb begin
    sel = rw_address[3:2];
    src_n = apply_strobe(src, write_data, write_strobe);
    dst_n = apply_strobe(dst, write_data, write_strobe);
    len_n = apply_strobe({16'd0, len}, write_data, write_strobe);
    ctrl_wr = write_request && sel == REG_CTRL && write_strobe[0];
    start = ctrl_wr && write_data[CTRL_START] && !busy;
    done_clr = ctrl_wr && write_data[CTRL_DONE];
    ctrl = '0;
    ctrl[CTRL_BUSY] = busy;
    ctrl[CTRL_DONE] = done;
    ctrl[CTRL_IE] = ie;
    rdata = sel == REG_SRC ? src : sel == REG_DST ? dst : sel == REG_LEN ? {16'd0, len} : ctrl;
  end
  // register state, handshakes, done (set wins over clear) and irq
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src <= '0;
      dst <= '0;
      len <= '0;
      ie <= 1'b0;
      done <= 1'b0;
      irq <= 1'b0;
      read_data <= '0;
      read_response <= 1'b0;
      write_response <= 1'b0;
    end else begin
      read_response <= read_request;
      write_response <= write_request;
      if (read_request) read_data <= rdata;
      if (write_request && !busy && sel == REG_SRC) src <= src_n;
      if (write_request && !busy && sel == REG_DST) dst <= {dst_n[31:2], 2'b00};
      if (write_request && !busy && sel == REG_LEN) len <= len_n[15:0];
      if (ctrl_wr) ie <= write_data[CTRL_IE];
      done <= done_set ? 1'b1 : done_clr ? 1'b0 : done;
      irq <= (done_set && ie) ? 1'b1 : (irq_response || done_clr) ? 1'b0 : irq;
    end
  end
endmodule

// File: rtl/rvsteel_dma.sv
// rvsteel_dma: word-copy DMA engine with managed and manager bus ports
module rvsteel_dma
  import rvsteel_dma_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
  output logic [31:0] m_rw_address,
  input  logic [31:0] m_read_data,
  output logic        m_read_request,
  input  logic        m_read_response,
  output logic [31:0] m_write_data,
  output logic [3:0]  m_write_strobe,
  output logic        m_write_request,
  input  logic        m_write_response,
  output logic        irq,
  input  logic        irq_response
);
  logic [1:0]  state;
  logic [31:0] cur_src, cur_dst, word, src, dst;
  logic [15:0] remaining, len;
  logic        start, busy, done_set;
  rvsteel_dma_regs regs (
    .clock(clock), .reset(reset), .rw_address(rw_address), .read_data(read_data),
    .read_request(read_request), .read_response(read_response), .write_data(write_data),
    .write_strobe(write_strobe), .write_request(write_request), .write_response(write_response),
    .irq(irq), .irq_response(irq_response), .busy(busy), .done_set(done_set), .start(start),
    .src(src), .dst(dst), .len(len)
  );
  // manager outputs derive from state only, so reset drops them at once
  always_comb begin
    busy = state != ST_IDLE;
    done_set = (state == ST_IDLE && start && len == 16'd0) || state == ST_FINISH;
    m_read_request = state == ST_READ;
    m_write_request = state == ST_WRITE;
    m_rw_address = m_read_request ? cur_src : m_write_request ? cur_dst : 32'd0;
    m_write_data = m_write_request ? word : 32'd0;
    m_write_strobe = m_write_request ? 4'b1111 : 4'b0000;
  end
  // transfer sequencing over working copies of the programmed registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cur_src <= '0;
      cur_dst <= '0;
      remaining <= '0;
      word <= '0;
    end else if (state == ST_IDLE) begin
      if (start && len != 16'd0) begin
        state <= ST_READ;
        cur_src <= src;
        cur_dst <= dst;
        remaining <= len;
      end
    end else if (state == ST_READ) begin
      if (m_read_response) begin
        word <= m_read_data;
        state <= ST_WRITE;
      end
    end else if (state == ST_WRITE) begin
      if (m_write_response) begin
        cur_src <= cur_src + 32'd4;
        cur_dst <= cur_dst + 32'd4;
        remaining <= remaining - 16'd1;
        state <= remaining == 16'd1 ? ST_FINISH : ST_READ;
      end
    end else begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_rvsteel_dma.sv
// tb_rvsteel_dma: scoreboard bench for the DMA register file and bus engine
module tb_rvsteel_dma;
  logic        clock, reset;
  logic [31:0] rw_address, read_data, write_data;
  logic        read_request, read_response, write_request, write_response;
  logic [3:0]  write_strobe;
  logic [31:0] m_rw_address, m_read_data, m_write_data;
  logic        m_read_request, m_read_response, m_write_request, m_write_response;
  logic [3:0]  m_write_strobe;
  logic        irq, irq_response;

  typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } xfer_t;
  xfer_t sb[$];
  int passed = 0, total = 0;
  int rd_dly = 0, wr_dly = 0, wait_cnt = 0, req_seen = 0;
  bit in_req = 0;
  logic [31:0] held_addr;
  logic held_wr;

  rvsteel_dma dut (
    .clock(clock), .reset(reset), .rw_address(rw_address), .read_data(read_data),
    .read_request(read_request), .read_response(read_response), .write_data(write_data),
    .write_strobe(write_strobe), .write_request(write_request), .write_response(write_response),
    .m_rw_address(m_rw_address), .m_read_data(m_read_data), .m_read_request(m_read_request),
    .m_read_response(m_read_response), .m_write_data(m_write_data), .m_write_strobe(m_write_strobe),
    .m_write_request(m_write_request), .m_write_response(m_write_response),
    .irq(irq), .irq_response(irq_response)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clock);
    rw_address = a; write_data = d; write_strobe = s; write_request = 1;
    @(posedge clock);
    #1 write_request = 0;
    chk("wr_resp", {31'd0, write_response}, 1);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clock);
    rw_address = a; read_request = 1;
    @(posedge clock);
    #1 read_request = 0;
    chk("rd_resp", {31'd0, read_response}, 1);
    d = read_data;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic expect_xfer(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{1'b0, s + 32'(4 * i), 32'd0});
      sb.push_back('{1'b1, d + 32'(4 * i), mem_val(s + 32'(4 * i))});
    end
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] v;
    int n = 0;
    do begin
      rd(32'hC, v);
      n++;
    end while (v[1] && n < 500);
    chk({tag, "_timeout"}, {31'd0, v[1]}, 0);
  endtask

  // bus responder: stability checks, programmable latency, scoreboard pop
  always @(negedge clock) begin
    m_read_response = 0;
    m_write_response = 0;
    if (reset) in_req = 0;
    else if (m_read_request || m_write_request) begin
      chk("excl", {31'd0, m_read_request & m_write_request}, 0);
      if (!in_req) begin
        in_req = 1; wait_cnt = 0; held_addr = m_rw_address; held_wr = m_write_request; req_seen++;
      end else begin
        chk("hold_addr", m_rw_address, held_addr);
        chk("hold_kind", {31'd0, m_write_request}, {31'd0, held_wr});
      end
      if (wait_cnt >= (held_wr ? wr_dly : rd_dly)) begin
        xfer_t e;
        if (held_wr) m_write_response = 1;
        else begin
          m_read_response = 1;
          m_read_data = mem_val(m_rw_address);
        end
        chk("sb_nonempty", {31'd0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("kind", {31'd0, held_wr}, {31'd0, e.wr});
          chk("addr", m_rw_address, e.addr);
          if (held_wr) begin
            chk("wdata", m_write_data, e.data);
            chk("wstrb", {28'd0, m_write_strobe}, 32'hF);
          end
        end
        in_req = 0;
      end else wait_cnt++;
    end
  end

  initial begin
    int n0;
    bit found;
    reset = 1; rw_address = 0; write_data = 0; write_strobe = 0;
    read_request = 0; write_request = 0; m_read_data = 0; irq_response = 0;
    repeat (3) @(negedge clock);
    chk("rst_rdata", read_data, 0);
    chk("rst_resp", {30'd0, read_response, write_response}, 0);
    chk("rst_mreq", {30'd0, m_read_request, m_write_request}, 0);
    chk("rst_maddr", m_rw_address, 0);
    chk("rst_mwd", m_write_data, 0);
    chk("rst_misc", {27'd0, m_write_strobe, irq}, 0);
    reset = 0;
    rd_chk("rst_src", 32'h0, 0);
    rd_chk("rst_ctrl", 32'hC, 0);
    wr(32'h4, 32'h0000_0203, 4'hF);
    rd_chk("dst_align", 32'h4, 32'h0000_0200);
    wr(32'h0, 32'hFFFF_FFFF, 4'b0011);
    rd_chk("src_strobe", 32'h0, 32'h0000_FFFF);
    wr(32'h8, 32'hABCD_1234, 4'hF);
    rd_chk("len_mask", 32'h8, 32'h0000_1234);

    rd_dly = 5; wr_dly = 1;
    wr(32'h0, 32'h100, 4'hF);
    wr(32'h4, 32'h200, 4'hF);
    wr(32'h8, 3, 4'hF);
    expect_xfer(32'h100, 32'h200, 3);
    wr(32'hC, 1, 4'h1);
    rd_chk("busy", 32'hC, 32'h2);
    wr(32'h0, 32'h999, 4'hF);
    rd_chk("src_locked", 32'h0, 32'h100);
    wr(32'hC, 1, 4'h1);
    wait_idle("xfer3");
    rd_chk("xfer3_ctrl", 32'hC, 32'h4);
    chk("xfer3_sb", sb.size(), 0);
    rd_chk("src_kept", 32'h0, 32'h100);
    wr(32'hC, 32'h4, 4'h1);
    rd_chk("done_clr", 32'hC, 0);

    rd_dly = 0; wr_dly = 0;
    wr(32'h8, 0, 4'hF);
    n0 = req_seen;
    wr(32'hC, 1, 4'h1);
    rd_chk("len0_done", 32'hC, 32'h4);
    repeat (20) @(negedge clock);
    chk("len0_nobus", req_seen, n0);

    wr(32'hC, 32'h4, 4'h1);
    wr(32'h0, 32'h300, 4'hF);
    wr(32'h4, 32'h400, 4'hF);
    wr(32'h8, 1, 4'hF);
    expect_xfer(32'h300, 32'h400, 1);
    chk("irq_idle", {31'd0, irq}, 0);
    wr(32'hC, 32'h9, 4'h1);
    wait_idle("irq");
    chk("irq_set", {31'd0, irq}, 1);
    @(negedge clock) irq_response = 1;
    @(posedge clock);
    #1 irq_response = 0;
    chk("irq_ack", {31'd0, irq}, 0);
    rd_chk("irq_ctrl", 32'hC, 32'hC);
    wr(32'hC, 32'hC, 4'h1);
    rd_chk("irq_done_clr", 32'hC, 32'h8);

    wr(32'h0, 32'hFFFF_FFFC, 4'hF);
    wr(32'h4, 32'h10, 4'hF);
    wr(32'h8, 2, 4'hF);
    expect_xfer(32'hFFFF_FFFC, 32'h10, 2);
    wr(32'hC, 32'h9, 4'h1);
    wait_idle("wrap");
    chk("wrap_sb", sb.size(), 0);

    wr_dly = 10;
    wr(32'h0, 32'h500, 4'hF);
    wr(32'h4, 32'h600, 4'hF);
    wr(32'h8, 4, 4'hF);
    expect_xfer(32'h500, 32'h600, 4);
    wr(32'hC, 1, 4'h1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clock);
      found = m_write_request;
    end
    chk("mid_write_seen", {31'd0, found}, 1);
    #2 reset = 1;
    #1;
    chk("arst_mreq", {30'd0, m_read_request, m_write_request}, 0);
    chk("arst_maddr", m_rw_address, 0);
    chk("arst_mwd", {m_write_data[31:4], m_write_strobe}, 0);
    repeat (2) @(negedge clock);
    sb.delete();
    reset = 0;
    n0 = req_seen;
    rd_chk("post_src", 32'h0, 0);
    rd_chk("post_dst", 32'h4, 0);
    rd_chk("post_len", 32'h8, 0);
    rd_chk("post_ctrl", 32'hC, 0);
    repeat (10) @(negedge clock);
    chk("no_resume", req_seen, n0);
    chk("post_irq", {31'd0, irq}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
